// File: rtl/secure_mem_reader.sv
// secure_mem_reader: load-side reader for the encrypted data memory.
// It checks the access key and then fetches one word over a read port that allows
// only one read in flight. Words at secure addresses are decrypted by a restoring
// divide-by-3, one quotient bit per cycle, followed by removal of the offset.
// Optional feature macro: SEC_READ_TIMEOUT_EN. When it is defined, the wait for
// memory is bounded and ends with an error response if no data arrives.
module secure_mem_reader #(
  parameter logic [9:0]  SECURE_BASE    = 10'd128,
  parameter logic [15:0] ACCESS_KEY     = 16'h0032,
  parameter logic [31:0] ENC_OFFSET     = 32'd142
`ifdef SEC_READ_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_addr,
  input  logic [15:0] req_key,
  output logic        mem_rd_en,
  output logic [9:0]  mem_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, DIVIDE, RESP} state_t;

  state_t      state, state_nxt;
  logic [9:0]  addr_q;
  logic [31:0] dvd_q;      // holds the dividend and collects quotient bits from the LSB end
  logic [1:0]  rem_q;      // the remainder of a division by 3 is always below 3
  logic [4:0]  div_cnt;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  logic        key_ok;
  logic        is_secure;
  logic        div_last;
  logic [2:0]  trial;
  logic [2:0]  trial_sub;
  logic        q_bit;
  logic [1:0]  rem_nxt;
  logic        timeout_hit;

  assign key_ok    = (req_key == ACCESS_KEY);
  assign is_secure = (addr_q > SECURE_BASE);
  assign div_last  = (div_cnt == 5'd31);

  // One restoring step: bring down the next dividend bit and subtract 3 if it fits.
  assign trial     = {rem_q, dvd_q[31]};
  assign trial_sub = trial - 3'd3;
  assign q_bit     = (trial >= 3'd3);
  assign rem_nxt   = q_bit ? trial_sub[1:0] : trial[1:0];

`ifdef SEC_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wait_cnt;

  // The limit is reached on the last of TIMEOUT_CYCLES cycles spent in MEM_WAIT.
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in MEM_WAIT. The count restarts whenever a read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == MEM_REQ) begin
      wait_cnt <= '0;
    end else if (state == MEM_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can leave it unassigned and infer a latch.
    state_nxt = state;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = key_ok ? MEM_REQ : RESP;
      end
      MEM_REQ: begin
        mem_rd_en = 1'b1;
        state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        // If data and the timeout arrive in the same cycle, the data wins.
        if (mem_rd_valid)     state_nxt = is_secure ? DIVIDE : RESP;
        else if (timeout_hit) state_nxt = RESP;
      end
      DIVIDE: begin
        if (div_last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture the address, load the divider, run it, and build the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      div_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            rsp_err_q  <= ~key_ok;
            rsp_data_q <= '0;
          end
        end
        MEM_REQ: begin
          rem_q   <= '0;
          div_cnt <= '0;
        end
        MEM_WAIT: begin
          if (mem_rd_valid) begin
            if (is_secure) dvd_q      <= mem_rd_data;
            else           rsp_data_q <= mem_rd_data;
          end else if (timeout_hit) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        DIVIDE: begin
          dvd_q   <= {dvd_q[30:0], q_bit};
          rem_q   <= rem_nxt;
          div_cnt <= div_cnt + 5'd1;
          // The offset is removed modulo 2^32. A wrap is the intended result, not an error.
          if (div_last) rsp_data_q <= {dvd_q[30:0], q_bit} - ENC_OFFSET;
        end
        RESP: begin
          if (rsp_ready) rsp_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_secure_mem_reader.sv
// Testbench for secure_mem_reader. Expected responses go onto a scoreboard queue
// when each request is driven, and they are popped and compared when the DUT
// responds. Inputs change on the falling edge, and outputs are sampled there too.
module tb_secure_mem_reader;

  localparam logic [15:0] KEY = 16'h0032;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_addr = '0;
  logic [15:0] req_key = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Memory model: answers each read strobe one cycle later with mem_word.
  logic [31:0] mem_word = '0;
  logic        mem_respond = 1'b1;
  logic        mem_pending = 1'b0;
  int          strobe_cnt = 0;
  logic [9:0]  strobe_addr = '0;

  secure_mem_reader dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_key      (req_key),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (mem_pending) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_word;
        mem_pending  = 1'b0;
      end
      if (mem_rd_en) begin
        strobe_cnt  = strobe_cnt + 1;
        strobe_addr = mem_addr;
        mem_pending = mem_respond;
      end
    end
  end

  // Drive a request and hold it until the accept edge has passed. Returns at a falling edge.
  task automatic send_req(input logic [9:0] a, input logic [15:0] k,
                          input logic [31:0] ed, input logic ee);
    int   n;
    logic rdy;
    exp_t e;
    n = 0;
    e.data = ed;
    e.err  = ee;
    sb.push_back(e);
    req_addr  = a;
    req_key   = k;
    req_valid = 1'b1;
    do begin
      rdy = req_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 100);
    req_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%0d: request not accepted", a);
    end
  endtask

  // Wait for rsp_valid. The latency is the number of edges after the accept edge.
  // Then pop and compare the expected response, hold off the response for `hold`
  // cycles, and complete the handshake if do_hs is set.
  task automatic wait_rsp(input string name, input int exp_lat, input int hold, input bit do_hs);
    int   lat;
    exp_t e;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges (rsp_valid=%b), want %0d", name, lat, rsp_valid, exp_lat);
    end
    e.data = 32'hx;
    e.err  = 1'bx;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: response with no expected entry", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        errors++;
        $display("FAIL %s_data: got data=%h err=%b, want data=%h err=%b",
                 name, rsp_data, rsp_err, e.data, e.err);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold%0d: got valid=%b data=%h err=%b req_ready=%b, want 1 %h %b 0",
                 name, i, rsp_valid, rsp_data, rsp_err, req_ready, e.data, e.err);
      end
    end
    if (do_hs) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL %s_handshake: got valid=%b req_ready=%b busy=%b err=%b, want 0 1 0 0",
                 name, rsp_valid, req_ready, busy, rsp_err);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 ||
        rsp_err !== 1'b0 || busy !== 1'b0 || mem_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b rd_en=%b valid=%b data=%h err=%b busy=%b addr=%0d, want 1 0 0 0 0 0 0",
               req_ready, mem_rd_en, rsp_valid, rsp_data, rsp_err, busy, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_secure();
    int s0;
    s0 = strobe_cnt;
    mem_word = 32'h000001DA;
    send_req(10'd200, KEY, 32'h00000010, 1'b0);
    wait_rsp("secure", 34, 0, 1'b1);
    checks++;
    if (strobe_cnt !== s0 + 1 || strobe_addr !== 10'd200) begin
      errors++;
      $display("FAIL secure_strobe: got %0d strobes at addr %0d, want 1 at 200", strobe_cnt - s0, strobe_addr);
    end
  endtask

  task automatic test_passthrough();
    mem_word = 32'hDEADBEEF;
    send_req(10'd128, KEY, 32'hDEADBEEF, 1'b0);
    wait_rsp("pass_128", 2, 0, 1'b1);
    send_req(10'd50, KEY, 32'hDEADBEEF, 1'b0);
    wait_rsp("pass_50", 2, 0, 1'b1);
    checks++;
    if (strobe_addr !== 10'd50) begin
      errors++;
      $display("FAIL pass_strobe_addr: got %0d, want 50", strobe_addr);
    end
  endtask

  // Address 129 is the first secure address: 447 / 3 = 149, and 149 - 142 = 7.
  task automatic test_boundary();
    mem_word = 32'd447;
    send_req(10'd129, KEY, 32'd7, 1'b0);
    wait_rsp("secure_129", 34, 0, 1'b1);
  endtask

  task automatic test_bad_key();
    int s0;
    s0 = strobe_cnt;
    mem_word = 32'hCAFEF00D;
    // The accept edge itself raises rsp_valid, so no further edges are expected.
    send_req(10'd300, 16'h0031, 32'h0, 1'b1);
    wait_rsp("bad_key", 0, 0, 1'b1);
    checks++;
    if (strobe_cnt !== s0) begin
      errors++;
      $display("FAIL bad_key_no_strobe: got %0d strobes, want 0", strobe_cnt - s0);
    end
  endtask

  // 3 / 3 = 1, and 1 - 142 wraps to FFFFFF73. The response is held off for 5 cycles.
  task automatic test_backpressure_wrap();
    mem_word = 32'h00000003;
    send_req(10'd500, KEY, 32'hFFFFFF73, 1'b0);
    wait_rsp("wrap_bp", 34, 5, 1'b1);
  endtask

  // A request waiting during RESP is not taken on the handshake edge, only on the next edge.
  task automatic test_back_to_back();
    exp_t e;
    mem_word = 32'h12345678;
    send_req(10'd50, KEY, 32'h12345678, 1'b0);
    wait_rsp("b2b_first", 2, 0, 1'b0);
    mem_word  = 32'd447;
    req_addr  = 10'd129;
    req_key   = KEY;
    req_valid = 1'b1;
    e.data = 32'd7;
    e.err  = 1'b0;
    sb.push_back(e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_same_edge: got req_ready=%b busy=%b valid=%b, want 1 0 0", req_ready, busy, rsp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    wait_rsp("b2b_second", 34, 0, 1'b1);
  endtask

  task automatic test_reset_mid_divide();
    mem_word = 32'h000001DA;
    send_req(10'd200, KEY, 32'h00000010, 1'b0);
    repeat (12) @(negedge clk);   // DIVIDE is entered after edge 2; 10 divide steps are now done
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_divide_state: got busy=%b valid=%b, want 1 0", busy, rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'h0 ||
        rsp_err !== 1'b0 || mem_addr !== 10'h0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b valid=%b busy=%b data=%h err=%b addr=%0d, want 1 0 0 0 0 0",
               req_ready, rsp_valid, busy, rsp_data, rsp_err, mem_addr);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_req(10'd200, KEY, 32'h00000010, 1'b0);
    wait_rsp("after_reset", 34, 0, 1'b1);
  endtask

`ifdef SEC_READ_TIMEOUT_EN
  // With no memory answer, MEM_WAIT lasts 64 cycles and ends on edge 65.
  task automatic test_timeout();
    mem_respond = 1'b0;
    send_req(10'd200, KEY, 32'h0, 1'b1);
    wait_rsp("timeout", 65, 0, 1'b1);
    mem_respond = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_secure();
    test_passthrough();
    test_bad_key();
    test_backpressure_wrap();
    test_boundary();
    test_back_to_back();
    test_reset_mid_divide();
`ifdef SEC_READ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
